// File: rtl/scn4m_subm_1rw1r_sram.sv
// 1RW + 1R behavioural SRAM with byte-lane write masks and a post-reset clear sequencer.
// Optional macro SRAM_COLLISION_CHECK_EN adds the registered collision1 output.

module scn4m_subm_1rw1r_sram_lane #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk0,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [W-1:0]  rdata0_o,
  output logic [W-1:0]  rdata1_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk0)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  // Unregistered reads; the top samples these at the same edge a write lands,
  // which is what yields read-before-write on a collision.
  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];
endmodule

module scn4m_subm_1rw1r_sram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int unsigned WMASK_WIDTH = 8,
  parameter int unsigned NUM_WMASKS  = DATA_WIDTH / WMASK_WIDTH,
  parameter int unsigned VERBOSE     = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
`ifdef SRAM_COLLISION_CHECK_EN
  output logic                  collision1,
`endif
  output logic                  init_busy
);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   dout0_q, dout1_q;

  logic                    x0, x1;
  logic                    a0_ok, a1_ok;
  logic                    rd0, wr0, rd1;
  logic [NUM_WMASKS-1:0]   lane_we_d;
  logic [ADDR_WIDTH-1:0]   waddr_d;
  logic [NUM_WMASKS-1:0][WMASK_WIDTH-1:0] wdata_d, din_lanes, rdata0, rdata1;

`ifndef SYNTHESIS
  assign x0 = $isunknown({csb0, web0});
  assign x1 = $isunknown(csb1);
`else
  assign x0 = 1'b0;
  assign x1 = 1'b0;
`endif

  assign a0_ok     = {1'b0, addr0} < DEPTH;
  assign a1_ok     = {1'b0, addr1} < DEPTH;
  assign rd0       = !x0 && !csb0 && web0;
  assign wr0       = !x0 && !csb0 && !web0;
  assign rd1       = !x1 && !csb1;
  assign din_lanes = din0;

  // The clear sequencer borrows the port 0 write path; reset cycles touch nothing.
  always_comb begin
    lane_we_d = '0;
    waddr_d   = addr0;
    wdata_d   = din_lanes;
    if (!rst0 && state_q == CLEAR) begin
      lane_we_d = '1;
      waddr_d   = ptr_q;
      wdata_d   = '0;
    end else if (!rst0 && state_q == IDLE && wr0 && a0_ok) begin
      lane_we_d = wmask0;
    end
  end

  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
    scn4m_subm_1rw1r_sram_lane #(
      .W(WMASK_WIDTH), .DEPTH(RAM_DEPTH), .AW(ADDR_WIDTH)
    ) u_lane (
      .clk0    (clk0),
      .we_i    (lane_we_d[i]),
      .waddr_i (waddr_d),
      .wdata_i (wdata_d[i]),
      .raddr0_i(addr0),
      .raddr1_i(addr1),
      .rdata0_o(rdata0[i]),
      .rdata1_o(rdata1[i])
    );
  end

`ifdef SRAM_COLLISION_CHECK_EN
  logic coll_hit, coll_q;
  assign coll_hit   = wr0 && rd1 && a0_ok && (addr0 == addr1) && (|wmask0);
  assign collision1 = coll_q;
`endif

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      dout0_q <= '0;
      dout1_q <= '0;
`ifdef SRAM_COLLISION_CHECK_EN
      coll_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        CLEAR: begin
          dout0_q <= '0;
          dout1_q <= '0;
          ptr_q   <= ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`ifdef SRAM_COLLISION_CHECK_EN
          coll_q  <= 1'b0;
`endif
        end
        IDLE: begin
          if (x0)       dout0_q <= 'x;
          else if (rd0) dout0_q <= a0_ok ? rdata0 : 'x;
          if (x1)       dout1_q <= 'x;
          else if (rd1) dout1_q <= a1_ok ? rdata1 : 'x;
`ifdef SRAM_COLLISION_CHECK_EN
          coll_q  <= coll_hit;
`endif
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign init_busy = busy_q;

`ifndef SYNTHESIS
  always @(posedge clk0) begin
    if (!rst0 && state_q == CLEAR) begin
      if (VERBOSE != 0 && (csb0 !== 1'b1 || csb1 !== 1'b1))
        $display("%m WARNING: access ignored while clear sequencer busy");
    end else if (!rst0 && state_q == IDLE) begin
      if (x0) $display("%m WARNING: X/Z on csb0/web0");
      if (x1) $display("%m WARNING: X/Z on csb1");
      if (!x0 && !csb0 && !a0_ok) $display("%m WARNING: port0 addr %0h out of range", addr0);
      if (!x1 && !csb1 && !a1_ok) $display("%m WARNING: port1 addr %0h out of range", addr1);
      if (VERBOSE != 0 && wr0 && a0_ok)
        $display("%m write addr=%0h din=%0h mask=%0b", addr0, din0, wmask0);
      if (VERBOSE != 0 && rd0 && a0_ok) $display("%m read0 addr=%0h", addr0);
      if (VERBOSE != 0 && rd1 && a1_ok) $display("%m read1 addr=%0h", addr1);
`ifdef SRAM_COLLISION_CHECK_EN
      if (coll_hit) $display("%m WARNING: port0 write / port1 read collision at %0h", addr0);
`endif
    end
  end
`endif
endmodule

// File: tb/tb_scn4m_subm_1rw1r_sram.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic vs an array model.
module tb_scn4m_subm_1rw1r_sram;
  localparam int DW = 32, AW = 8, NM = 4, DEPTH = 256;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1, csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [NM-1:0] wmask0 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] din0 = '0, dout0, dout1;
  logic          init_busy;
`ifdef SRAM_COLLISION_CHECK_EN
  logic          collision1;
  logic          exp_coll = 1'b0;
`endif

  int checks = 0, errors = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp0 = '0, exp1 = '0;

  always #5 clk0 = ~clk0;

  scn4m_subm_1rw1r_sram #(.VERBOSE(0)) dut (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0), .csb1(csb1), .addr1(addr1),
    .dout1(dout1),
`ifdef SRAM_COLLISION_CHECK_EN
    .collision1(collision1),
`endif
    .init_busy(init_busy));

  task automatic step();
    @(posedge clk0); #1;
  endtask

  task automatic deselect();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp0 = '0; exp1 = '0;
  endtask

  // One idle-mode cycle: reads see memory before this cycle's write.
  task automatic drive(input logic c0, input logic w0, input logic [NM-1:0] m,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d,
                       input logic c1, input logic [AW-1:0] a1);
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    if (!c0 && w0) exp0 = model[a0];
    if (!c1)       exp1 = model[a1];
`ifdef SRAM_COLLISION_CHECK_EN
    exp_coll = !c0 && !w0 && !c1 && (a0 == a1) && (m != 0);
`endif
    if (!c0 && !w0)
      for (int b = 0; b < NM; b++)
        if (m[b]) model[a0][b*8 +: 8] = d[b*8 +: 8];
    step();
  endtask

  task automatic test_reset();
    int cnt;
    deselect(); rst0 = 1'b1;
    step(); step();
    checks++; if (dout0 !== '0) begin errors++; $display("FAIL reset_dout0 got %h exp 0", dout0); end
    checks++; if (dout1 !== '0) begin errors++; $display("FAIL reset_dout1 got %h exp 0", dout1); end
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", init_busy); end
    rst0 = 1'b0; cnt = 0;
    while (cnt < 1000) begin
      step(); cnt++;
      if (init_busy !== 1'b1) break;
    end
    checks++; if (cnt != 256) begin errors++; $display("FAIL clear_len got %0d exp 256", cnt); end
    clear_model();
  endtask

  task automatic test_clear_read();
    drive(0, 1, '0, 8'h00, '0, 0, 8'hFF);
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL clr_rd0_00 got %h exp 0", dout0); end
    checks++; if (dout1 !== 32'h0) begin errors++; $display("FAIL clr_rd1_ff got %h exp 0", dout1); end
    drive(0, 1, '0, 8'hFF, '0, 0, 8'h00);
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL clr_rd0_ff got %h exp 0", dout0); end
    checks++; if (dout1 !== 32'h0) begin errors++; $display("FAIL clr_rd1_00 got %h exp 0", dout1); end
  endtask

  task automatic test_masked_write();
    drive(0, 0, 4'b1111, 8'h10, 32'hDEADBEEF, 1, '0);
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL wr_holds_dout0 got %h exp 0", dout0); end
    drive(0, 0, 4'b0101, 8'h10, 32'h11223344, 1, '0);
    drive(0, 1, '0, 8'h10, '0, 1, '0);
    checks++; if (dout0 !== 32'hDE22BE44) begin errors++; $display("FAIL masked_rd got %h exp DE22BE44", dout0); end
    drive(0, 0, 4'b0000, 8'h10, 32'hFFFFFFFF, 1, '0);
    drive(0, 1, '0, 8'h10, '0, 1, '0);
    checks++; if (dout0 !== 32'hDE22BE44) begin errors++; $display("FAIL nomask_wr got %h exp DE22BE44", dout0); end
  endtask

  task automatic test_dual_read();
    drive(0, 0, 4'b1111, 8'h20, 32'hCAFEF00D, 1, '0);
    drive(0, 1, '0, 8'h10, '0, 0, 8'h20);
    checks++; if (dout0 !== 32'hDE22BE44) begin errors++; $display("FAIL dual_rd0 got %h exp DE22BE44", dout0); end
    checks++; if (dout1 !== 32'hCAFEF00D) begin errors++; $display("FAIL dual_rd1 got %h exp CAFEF00D", dout1); end
  endtask

  task automatic test_collision();
    drive(0, 0, 4'b1111, 8'h20, 32'h55555555, 0, 8'h20);
    checks++; if (dout1 !== 32'hCAFEF00D) begin errors++; $display("FAIL coll_old got %h exp CAFEF00D", dout1); end
`ifdef SRAM_COLLISION_CHECK_EN
    checks++; if (collision1 !== 1'b1) begin errors++; $display("FAIL coll_flag got %b exp 1", collision1); end
`endif
    drive(1, 1, '0, '0, '0, 0, 8'h20);
    checks++; if (dout1 !== 32'h55555555) begin errors++; $display("FAIL coll_new got %h exp 55555555", dout1); end
`ifdef SRAM_COLLISION_CHECK_EN
    checks++; if (collision1 !== 1'b0) begin errors++; $display("FAIL coll_clr got %b exp 0", collision1); end
`endif
  endtask

  task automatic test_hold();
    drive(0, 1, '0, 8'h10, '0, 0, 8'h20);
    deselect();
    for (int i = 0; i < 5; i++) begin
      addr0 = 8'($urandom); addr1 = 8'($urandom); din0 = $urandom;
      step();
      checks++; if (dout0 !== exp0) begin errors++; $display("FAIL hold0 c%0d got %h exp %h", i, dout0, exp0); end
      checks++; if (dout1 !== exp1) begin errors++; $display("FAIL hold1 c%0d got %h exp %h", i, dout1, exp1); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
            8'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)));
      checks++; if (dout0 !== exp0) begin errors++; $display("FAIL rand0 i%0d got %h exp %h", i, dout0, exp0); end
      checks++; if (dout1 !== exp1) begin errors++; $display("FAIL rand1 i%0d got %h exp %h", i, dout1, exp1); end
`ifdef SRAM_COLLISION_CHECK_EN
      checks++; if (collision1 !== exp_coll) begin errors++; $display("FAIL randc i%0d got %b exp %b", i, collision1, exp_coll); end
`endif
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    deselect(); rst0 = 1'b1; step(); step(); rst0 = 1'b0;
    for (int i = 0; i < 100; i++) step();
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", init_busy); end
    rst0 = 1'b1; step();
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy got %b exp 1", init_busy); end
    rst0 = 1'b0; cnt = 0;
    while (cnt < 1000) begin
      if (cnt == 199) begin
        csb0 = 0; web0 = 0; wmask0 = 4'hF; addr0 = 8'h30; din0 = 32'hA5A5A5A5;
        csb1 = 0; addr1 = 8'h10;
      end else deselect();
      step(); cnt++;
      if (cnt == 200) begin
        checks++; if (dout0 !== '0 || dout1 !== '0) begin
          errors++; $display("FAIL busy_dout got %h/%h exp 0/0", dout0, dout1); end
      end
      if (init_busy !== 1'b1) break;
    end
    checks++; if (cnt != 256) begin errors++; $display("FAIL mid_clear_len got %0d exp 256", cnt); end
    clear_model();
    drive(0, 1, '0, 8'h30, '0, 0, 8'h10);
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL busy_wr_drop got %h exp 0", dout0); end
    checks++; if (dout1 !== 32'h0) begin errors++; $display("FAIL recleared got %h exp 0", dout1); end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_clear_read();
    test_masked_write();
    test_dual_read();
    test_collision();
    test_hold();
    test_random();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
